// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed hex seven-segment driver.
// Segment vectors are ordered a..g with a at index 0. They are active-low,
// so a 0 lights a segment.
package hex_disp_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;

    localparam seg_t SEG_HEX_0 = 7'b0000001;
    localparam seg_t SEG_HEX_1 = 7'b1001111;
    localparam seg_t SEG_HEX_2 = 7'b0010010;
    localparam seg_t SEG_HEX_3 = 7'b0000110;
    localparam seg_t SEG_HEX_4 = 7'b1001100;
    localparam seg_t SEG_HEX_5 = 7'b0100100;
    localparam seg_t SEG_HEX_6 = 7'b0100000;
    localparam seg_t SEG_HEX_7 = 7'b0001111;
    localparam seg_t SEG_HEX_8 = 7'b0000000;
    localparam seg_t SEG_HEX_9 = 7'b0000100;
    localparam seg_t SEG_HEX_A = 7'b0001000;
    localparam seg_t SEG_HEX_B = 7'b1100000;
    localparam seg_t SEG_HEX_C = 7'b0110001;
    localparam seg_t SEG_HEX_D = 7'b1000010;
    localparam seg_t SEG_HEX_E = 7'b0110000;
    localparam seg_t SEG_HEX_F = 7'b0111000;

    // Load path: a captured value either waits for the frame boundary or does not.
    typedef enum logic {
        LD_IDLE    = 1'b0,
        LD_PENDING = 1'b1
    } load_state_t;

    // Blink phase: during PHASE_OFF the whole display is dark.
    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/hex_scan_display_seg7_lut.sv
// Hex nibble to active-low seven-segment glyph lookup. Purely combinational.
module seg7_lut
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    // Glyph table for 0-F.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// It scans one digit per SCAN_DIV clocks and supports leading-zero blanking,
// per-digit dash override, whole-display blink and frame-synchronous loads.
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned FRAME_SYNC   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Load,
    input  logic                  BlankLZ,
    input  logic [DIGITS-1:0]     DashMask,
    input  logic                  Blink,
    output logic [0:6]            Seg,
    output logic [DIGITS-1:0]     DigitSel,
    output logic                  Pending
);

    localparam int unsigned IW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int unsigned PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic          SYNC     = (FRAME_SYNC != 0);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frm_cnt;
    blink_phase_t          phase;

    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   shadow_nx;
    logic [4*DIGITS-1:0]   pend_val;
    logic [4*DIGITS-1:0]   pend_val_nx;
    load_state_t           ld_state;
    load_state_t           ld_state_nx;

    logic                  tick;
    logic                  frame_end;

    logic [3:0]            nib;
    seg_t                  glyph;
    logic [DIGITS-1:0]     lz_blank;
    logic                  upper_zero;
    logic                  disp_on;
    seg_t                  seg_nx;
    logic [DIGITS-1:0]     sel_nx;

    assign tick      = (presc == PRE_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // Scan timing: prescaler and digit index that wraps at the last digit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blink: count frames while enabled and toggle the phase every BLINK_FRAMES frames.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frm_cnt <= '0;
            phase   <= PHASE_ON;
        end else if (!Blink) begin
            frm_cnt <= '0;
            phase   <= PHASE_ON;
        end else if (frame_end) begin
            if (frm_cnt == FRM_LAST) begin
                frm_cnt <= '0;
                phase   <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frm_cnt <= frm_cnt + 1'b1;
            end
        end
    end

    // Load path state: shadow (displayed) value, pending value and pending state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ld_state <= LD_IDLE;
            shadow   <= '0;
            pend_val <= '0;
        end else begin
            ld_state <= ld_state_nx;
            shadow   <= shadow_nx;
            pend_val <= pend_val_nx;
        end
    end

    // Load path next state. A Load on the boundary cycle bypasses the pending
    // register so it is not held back by a whole extra frame.
    always_comb begin
        ld_state_nx = ld_state;
        shadow_nx   = shadow;
        pend_val_nx = pend_val;
        if (!SYNC) begin
            ld_state_nx = LD_IDLE;
            if (Load) begin
                shadow_nx = Value;
            end
        end else if (Load && frame_end) begin
            shadow_nx   = Value;
            ld_state_nx = LD_IDLE;
        end else if (Load) begin
            pend_val_nx = Value;
            ld_state_nx = LD_PENDING;
        end else if (frame_end && (ld_state == LD_PENDING)) begin
            shadow_nx   = pend_val;
            ld_state_nx = LD_IDLE;
        end
    end

    assign Pending = (ld_state == LD_PENDING);

    // Leading-zero blanking flags, walking from the most significant digit down.
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            int unsigned j;
            j          = DIGITS - 1 - k;
            upper_zero = upper_zero && (shadow[4*j +: 4] == 4'h0);
            lz_blank[j] = BlankLZ && upper_zero && (j != 0);
        end
    end

    assign nib = shadow[{idx, 2'b00} +: 4];

    seg7_lut u_lut (
        .nibble (nib),
        .seg    (glyph)
    );

    // Output selection: blink gate first, then dash > blank > glyph for the indexed digit.
    always_comb begin
        disp_on = (phase == PHASE_ON) || !Blink;
        seg_nx  = SEG_BLANK;
        sel_nx  = '1;
        if (disp_on) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                sel_nx[k] = (IW'(k) != idx);
            end
            if (DashMask[idx]) begin
                seg_nx = SEG_DASH;
            end else if (lz_blank[idx]) begin
                seg_nx = SEG_BLANK;
            end else begin
                seg_nx = glyph;
            end
        end
    end

    // Registered segment and digit-select pins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Seg      <= SEG_BLANK;
            DigitSel <= '1;
        end else begin
            Seg      <= seg_nx;
            DigitSel <= sel_nx;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with DIGITS=4, SCAN_DIV=2, BLINK_FRAMES=2.
// dut0 uses immediate loads and dut1 uses frame-synchronous loads. Both share the stimulus.
module tb_hex_scan_display;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Value = '0;
    logic        Load = 1'b0;
    logic        BlankLZ = 1'b0;
    logic [3:0]  DashMask = '0;
    logic        Blink = 1'b0;

    logic [0:6]  seg0, seg1;
    logic [3:0]  sel0, sel1;
    logic        pend0, pend1;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] G0   = 7'b0000001;
    localparam logic [6:0] G1   = 7'b1001111;
    localparam logic [6:0] G2   = 7'b0010010;
    localparam logic [6:0] G3   = 7'b0000110;
    localparam logic [6:0] G5   = 7'b0100100;
    localparam logic [6:0] GA   = 7'b0001000;
    localparam logic [6:0] GF   = 7'b0111000;
    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b1111110;

    always #5 Clk = ~Clk;

    hex_scan_display #(.DIGITS(4), .SCAN_DIV(2), .BLINK_FRAMES(2), .FRAME_SYNC(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load), .BlankLZ(BlankLZ),
        .DashMask(DashMask), .Blink(Blink), .Seg(seg0), .DigitSel(sel0), .Pending(pend0)
    );

    hex_scan_display #(.DIGITS(4), .SCAN_DIV(2), .BLINK_FRAMES(2), .FRAME_SYNC(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load), .BlankLZ(BlankLZ),
        .DashMask(DashMask), .Blink(Blink), .Seg(seg1), .DigitSel(sel1), .Pending(pend1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Load  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    function automatic logic [3:0] sel_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] s1_exp [4];
        int  d;
        bit  on;
        s1_exp[0] = GF; s1_exp[1] = GA; s1_exp[2] = G2; s1_exp[3] = G1;

        // Reset values while Reset is held
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_seg0", 16'(seg0), 16'(BLK));
        chk("rst_sel0", 16'(sel0), 16'hF);
        chk("rst_seg1", 16'(seg1), 16'(BLK));
        chk("rst_pend1", 16'(pend1), 16'h0);
        Reset = 1'b0;

        // Scenario 1: immediate load of 12AF
        step();                                             // E1
        chk("first_sel", 16'(sel0), 16'b1110);
        chk("first_seg", 16'(seg0), 16'(G0));
        Value = 16'h12AF; Load = 1'b1;
        step();                                             // E2
        Load = 1'b0;
        chk("e2_seg_old", 16'(seg0), 16'(G0));
        chk("fs0_pend", 16'(pend0), 16'h0);
        chk("fs1_pend_set", 16'(pend1), 16'h1);
        for (int e = 3; e <= 10; e++) begin
            step();
            d = ((e - 1) / 2) % 4;
            chk("s1_sel", 16'(sel0), 16'(sel_of(d)));
            chk("s1_seg", 16'(seg0), 16'(s1_exp[d]));
        end

        // Scenario 2: leading-zero blanking and dash override
        do_reset();
        BlankLZ = 1'b1; Value = 16'h0050; Load = 1'b1;
        step();                                             // E1
        Load = 1'b0;
        chk("lz_e1_seg", 16'(seg0), 16'(G0));
        step();                                             // E2
        chk("lz_d0_sel", 16'(sel0), 16'b1110);
        chk("lz_d0_seg", 16'(seg0), 16'(G0));
        step();                                             // E3
        chk("lz_d1_sel", 16'(sel0), 16'b1101);
        chk("lz_d1_seg", 16'(seg0), 16'(G5));
        step(); step();                                     // E5
        chk("lz_d2_sel", 16'(sel0), 16'b1011);
        chk("lz_d2_seg", 16'(seg0), 16'(BLK));
        step(); step();                                     // E7
        chk("lz_d3_sel", 16'(sel0), 16'b0111);
        chk("lz_d3_seg", 16'(seg0), 16'(BLK));
        step();                                             // E8
        Value = 16'h0000; Load = 1'b1;
        step();                                             // E9
        Load = 1'b0;
        chk("z_d0_seg", 16'(seg0), 16'(G0));
        step(); step();                                     // E11
        chk("z_d1_seg", 16'(seg0), 16'(BLK));
        step(); step();                                     // E13
        chk("z_d2_seg", 16'(seg0), 16'(BLK));
        step(); step();                                     // E15
        chk("z_d3_seg", 16'(seg0), 16'(BLK));
        DashMask = 4'b1000;
        step();                                             // E16
        chk("dash_live_sel", 16'(sel0), 16'b0111);
        chk("dash_live_seg", 16'(seg0), 16'(DASH));
        step();                                             // E17
        chk("dash_d0_seg", 16'(seg0), 16'(G0));
        step(); step();                                     // E19
        chk("dash_d1_seg", 16'(seg0), 16'(BLK));
        step(); step();                                     // E21
        chk("dash_d2_seg", 16'(seg0), 16'(BLK));
        step(); step();                                     // E23
        chk("dash_d3_seg", 16'(seg0), 16'(DASH));
        DashMask = '0; BlankLZ = 1'b0;

        // Scenario 3: frame-synchronous loads, last value wins
        do_reset();
        step();                                             // E1
        chk("fs_e1_sel", 16'(sel1), 16'b1110);
        step();                                             // E2
        Value = 16'h1111; Load = 1'b1;
        step();                                             // E3
        Load = 1'b0;
        chk("fs_pend_a", 16'(pend1), 16'h1);
        chk("fs_e3_seg", 16'(seg1), 16'(G0));
        step();                                             // E4
        Value = 16'h2222; Load = 1'b1;
        step();                                             // E5
        Load = 1'b0;
        chk("fs_pend_b", 16'(pend1), 16'h1);
        chk("fs_e5_seg", 16'(seg1), 16'(G0));
        step(); step();                                     // E7
        chk("fs_pend_c", 16'(pend1), 16'h1);
        chk("fs_e7_seg", 16'(seg1), 16'(G0));
        step();                                             // E8 frame boundary
        chk("fs_pend_clr", 16'(pend1), 16'h0);
        chk("fs_e8_seg", 16'(seg1), 16'(G0));
        for (int e = 9; e <= 15; e++) begin
            step();
            d = ((e - 1) / 2) % 4;
            chk("fs_new_sel", 16'(sel1), 16'(sel_of(d)));
            chk("fs_new_seg", 16'(seg1), 16'(G2));
        end
        Value = 16'h3333; Load = 1'b1;
        step();                                             // E16 boundary load
        Load = 1'b0;
        chk("fs_bnd_pend", 16'(pend1), 16'h0);
        chk("fs_bnd_old", 16'(seg1), 16'(G2));
        step();                                             // E17
        chk("fs_bnd_sel", 16'(sel1), 16'b1110);
        chk("fs_bnd_new", 16'(seg1), 16'(G3));

        // Scenario 4: blink 16 on, 16 off, then Blink=0 restores within a clock
        do_reset();
        Blink = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            step();
            on = (e <= 16) || (e >= 33 && e <= 48) || (e >= 50);
            d  = ((e - 1) / 2) % 4;
            chk("blink_sel", 16'(sel0), on ? 16'(sel_of(d)) : 16'hF);
            chk("blink_seg", 16'(seg0), on ? 16'(G0) : 16'(BLK));
            if (e == 49) Blink = 1'b0;
        end

        // Scenario 5: asynchronous reset mid-digit discards a pending load
        do_reset();
        step(); step();                                     // E2
        Value = 16'h4444; Load = 1'b1;
        step();                                             // E3
        Load = 1'b0;
        chk("ar_pend_set", 16'(pend1), 16'h1);
        #3;
        Reset = 1'b1;
        #1;
        chk("ar_seg1", 16'(seg1), 16'(BLK));
        chk("ar_sel1", 16'(sel1), 16'hF);
        chk("ar_pend1", 16'(pend1), 16'h0);
        chk("ar_sel0", 16'(sel0), 16'hF);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        step();                                             // E1
        chk("ar_e1_sel", 16'(sel1), 16'b1110);
        chk("ar_e1_seg", 16'(seg1), 16'(G0));
        step(); step();                                     // E3
        chk("ar_e3_sel", 16'(sel1), 16'b1101);
        repeat (6) step();                                  // E9
        chk("ar_e9_pend", 16'(pend1), 16'h0);
        chk("ar_e9_sel", 16'(sel1), 16'b1110);
        chk("ar_e9_seg", 16'(seg1), 16'(G0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
